// File: rtl/joy_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : joy_pkg
//  Purpose  : Shared constants, MSX pin ordering, routing FSM states and the
//             host-word to MSX-pin reorder helper for the joystick router.
//  Revision : 1.0 - initial release
// ============================================================================
package joy_pkg;

    // Bit positions inside one host joystick word (active-high)
    localparam int unsigned c_RIGHT = 0;
    localparam int unsigned c_LEFT  = 1;
    localparam int unsigned c_DOWN  = 2;
    localparam int unsigned c_UP    = 3;
    localparam int unsigned c_P6    = 4;
    localparam int unsigned c_P9    = 5;

    // Number of host bits that carry meaning; anything above is ignored
    localparam int unsigned c_USED_BITS = 6;

    // Pin positions inside one MSX port word {p9,p6,right,left,down,up}
    localparam int unsigned c_PIN_UP    = 0;
    localparam int unsigned c_PIN_DOWN  = 1;
    localparam int unsigned c_PIN_LEFT  = 2;
    localparam int unsigned c_PIN_RIGHT = 3;
    localparam int unsigned c_PIN_P6    = 4;
    localparam int unsigned c_PIN_P9    = 5;
    localparam int unsigned c_PIN_W     = 6;

    // Routing state machine encoding
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_QUIET = 2'd1,
        ST_APPLY      = 2'd2
    } route_state_t;

    // Reorder host bits into MSX pin order (still active-high)
    function automatic logic [c_PIN_W-1:0] to_msx_pins(input logic [c_USED_BITS-1:0] j);
        logic [c_PIN_W-1:0] p;
        p              = '0;
        p[c_PIN_UP]    = j[c_UP];
        p[c_PIN_DOWN]  = j[c_DOWN];
        p[c_PIN_LEFT]  = j[c_LEFT];
        p[c_PIN_RIGHT] = j[c_RIGHT];
        p[c_PIN_P6]    = j[c_P6];
        p[c_PIN_P9]    = j[c_P9];
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/joy_autofire.sv
`default_nettype none
// ============================================================================
//  Module   : joy_autofire
//  Purpose  : Per-source autofire: half-period counter and phase that chop the
//             masked fire buttons while they are held; other bits pass through.
//  Revision : 1.0 - initial release
// ============================================================================
module joy_autofire
    import joy_pkg::*;
(
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic                   i_tick,
    input  logic                   i_clear,
    input  logic                   i_af_en,
    input  logic [1:0]             i_af_mask,
    input  logic [1:0]             i_af_rate,
    input  logic [c_USED_BITS-1:0] i_joy,
    output logic [c_USED_BITS-1:0] o_joy
);

    logic       w_held;
    logic [4:0] w_limit;
    logic [4:0] r_cnt;
    logic       r_phase;

    // Autofire is live only when enabled and a masked fire button is down
    assign w_held  = i_af_en & (|({i_joy[c_P9], i_joy[c_P6]} & i_af_mask));
    // (af_rate+1)*8-1 is simply af_rate with three ones appended
    assign w_limit = {i_af_rate, 3'b111};

    // Half-period counter and phase; phase rests at 1 so a new press fires at once
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (i_clear || !w_held) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (i_tick) begin
            // >= so that a lowered rate wraps a counter already past the new limit
            if (r_cnt >= w_limit) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt <= r_cnt + 5'd1;
            end
        end
    end

    // Gate the masked fire bits with the phase; everything else passes through
    always_comb begin
        o_joy       = i_joy;
        o_joy[c_P6] = i_joy[c_P6] & (~(i_af_en & i_af_mask[0]) | r_phase);
        o_joy[c_P9] = i_joy[c_P9] & (~(i_af_en & i_af_mask[1]) | r_phase);
    end

endmodule
`default_nettype wire

// File: rtl/joy_router.sv
`default_nettype none
// ============================================================================
//  Module   : joy_router
//  Purpose  : Routes NUM_JOY host joysticks to NUM_JOY MSX ports with a
//             rotation that only changes after the sticks have been idle,
//             plus per-source autofire. Port outputs are registered, active-low.
//  Revision : 1.0 - initial release
// ============================================================================
module joy_router
    import joy_pkg::*;
#(
    parameter int NUM_JOY   = 2,
    parameter int JOY_W     = 16,
    parameter int AF_DIV    = 21477,
    parameter int QUIET_CYC = 2048
) (
    input  logic                        clk_sys,
    input  logic                        reset_n,
    input  logic [NUM_JOY*JOY_W-1:0]    joy_in,
    input  logic [$clog2(NUM_JOY)-1:0]  rot_req,
    input  logic [NUM_JOY-1:0]          af_en,
    input  logic [1:0]                  af_mask,
    input  logic [1:0]                  af_rate,
    output logic [NUM_JOY*c_PIN_W-1:0]  port_n,
    output logic [$clog2(NUM_JOY)-1:0]  rot_cur,
    output logic                        rot_busy
);

    localparam int ROT_W = $clog2(NUM_JOY);
    localparam int PRE_W = (AF_DIV > 1) ? $clog2(AF_DIV) : 1;
    localparam int QW    = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;

    logic [PRE_W-1:0]           r_pre;
    logic                       w_tick;
    route_state_t               r_state;
    route_state_t               w_state_next;
    logic [QW-1:0]              r_quiet;
    logic [QW-1:0]              w_quiet_next;
    logic [ROT_W-1:0]           r_rot_cur;
    logic [ROT_W-1:0]           w_rot_next;
    logic [ROT_W-1:0]           w_req_mod;
    logic                       w_clear;
    logic                       w_any_btn;
    logic                       w_unused_bits;
    logic [c_USED_BITS-1:0]     w_gated [NUM_JOY];
    logic [NUM_JOY*c_PIN_W-1:0] w_port_next_n;

    // Only the low six bits of each word are routed; the rest is deliberately dropped
    assign w_unused_bits = ^joy_in;

    assign rot_cur  = r_rot_cur;
    assign rot_busy = (r_state != ST_IDLE);

    // Free-running autofire prescaler: one-cycle tick at AF_DIV-1
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    assign w_tick = (r_pre == PRE_W'(AF_DIV - 1));

    // Out-of-range rotation requests fold back into 0..NUM_JOY-1
    always_comb begin
        w_req_mod = rot_req;
        if (int'(rot_req) >= NUM_JOY) begin
            w_req_mod = rot_req - ROT_W'(NUM_JOY);
        end
    end

    // Any meaningful button on any source counts as activity
    always_comb begin
        w_any_btn = 1'b0;
        for (int i = 0; i < NUM_JOY; i++) begin
            w_any_btn = w_any_btn | (|joy_in[i*JOY_W +: c_USED_BITS]);
        end
    end

    generate
        for (genvar i = 0; i < NUM_JOY; i++) begin : g_src
            joy_autofire u_af (
                .clk_sys   (clk_sys),
                .reset_n   (reset_n),
                .i_tick    (w_tick),
                .i_clear   (w_clear),
                .i_af_en   (af_en[i]),
                .i_af_mask (af_mask),
                .i_af_rate (af_rate),
                .i_joy     (joy_in[i*JOY_W +: c_USED_BITS]),
                .o_joy     (w_gated[i])
            );
        end
    endgenerate

    generate
        for (genvar k = 0; k < NUM_JOY; k++) begin : g_port
            int                     w_src;
            logic [c_USED_BITS-1:0] w_pick;

            // Port k takes source (k + rot_cur) mod NUM_JOY
            always_comb begin
                w_src = k + int'(r_rot_cur);
                if (w_src >= NUM_JOY) begin
                    w_src = w_src - NUM_JOY;
                end
                w_pick = '0;
                for (int j = 0; j < NUM_JOY; j++) begin
                    if (j == w_src) begin
                        w_pick = w_gated[j];
                    end
                end
            end

            assign w_port_next_n[k*c_PIN_W +: c_PIN_W] = ~to_msx_pins(w_pick);
        end
    endgenerate

    // Registered active-low port pins
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            port_n <= '1;
        end else begin
            port_n <= w_port_next_n;
        end
    end

    // Routing state, quiet counter and applied rotation
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_quiet   <= '0;
            r_rot_cur <= '0;
        end else begin
            r_state   <= w_state_next;
            r_quiet   <= w_quiet_next;
            r_rot_cur <= w_rot_next;
        end
    end

    // Next-state logic: a new rotation waits for QUIET_CYC idle cycles
    always_comb begin
        w_state_next = r_state;
        w_quiet_next = r_quiet;
        w_rot_next   = r_rot_cur;
        w_clear      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_mod != r_rot_cur) begin
                    w_state_next = ST_WAIT_QUIET;
                    w_quiet_next = '0;
                end
            end
            ST_WAIT_QUIET: begin
                if (w_req_mod == r_rot_cur) begin
                    w_state_next = ST_IDLE;
                    w_quiet_next = '0;
                end else if (w_any_btn) begin
                    w_quiet_next = '0;
                end else if (r_quiet == QW'(QUIET_CYC - 1)) begin
                    w_state_next = ST_APPLY;
                end else begin
                    w_quiet_next = r_quiet + 1'b1;
                end
            end
            ST_APPLY: begin
                // A press landing exactly in this cycle vetoes the swap so no
                // button ever hops ports; IDLE then re-arms the request.
                w_state_next = ST_IDLE;
                w_quiet_next = '0;
                w_clear      = 1'b1;
                if (!w_any_btn) begin
                    w_rot_next = w_req_mod;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_quiet_next = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_joy_router.sv
`default_nettype none
// ============================================================================
//  Module   : tb_joy_router
//  Purpose  : Scoreboard bench for joy_router: a 2-port and a 4-port instance,
//             expected outputs queued per cycle and checked by a monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_joy_router;

    logic clk_sys = 1'b0;
    logic reset_n;
    always #5 clk_sys = ~clk_sys;

    // Instance A: two sources, fast prescaler, full quiet time
    logic [31:0] joy_a;
    logic        rot_req_a;
    logic [1:0]  af_en_a;
    logic [1:0]  af_mask_a;
    logic [1:0]  af_rate_a;
    logic [11:0] port_n_a;
    logic        rot_cur_a;
    logic        rot_busy_a;

    // Instance B: four sources, short quiet time
    logic [63:0] joy_b;
    logic [1:0]  rot_req_b;
    logic [3:0]  af_en_b;
    logic [1:0]  af_mask_b;
    logic [1:0]  af_rate_b;
    logic [23:0] port_n_b;
    logic [1:0]  rot_cur_b;
    logic        rot_busy_b;

    joy_router #(.NUM_JOY(2), .JOY_W(16), .AF_DIV(4), .QUIET_CYC(2048)) u_dut_a (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .joy_in   (joy_a),
        .rot_req  (rot_req_a),
        .af_en    (af_en_a),
        .af_mask  (af_mask_a),
        .af_rate  (af_rate_a),
        .port_n   (port_n_a),
        .rot_cur  (rot_cur_a),
        .rot_busy (rot_busy_a)
    );

    joy_router #(.NUM_JOY(4), .JOY_W(16), .AF_DIV(4), .QUIET_CYC(16)) u_dut_b (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .joy_in   (joy_b),
        .rot_req  (rot_req_b),
        .af_en    (af_en_b),
        .af_mask  (af_mask_b),
        .af_rate  (af_rate_b),
        .port_n   (port_n_b),
        .rot_cur  (rot_cur_b),
        .rot_busy (rot_busy_b)
    );

    typedef struct {
        int          at;
        bit          dut;
        logic [23:0] pn;
        logic [1:0]  rc;
        logic        busy;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic expect_a(input int at, input logic [11:0] pn, input logic rc,
                            input logic busy, input string nm);
        exp_t e;
        e.at = at; e.dut = 1'b0; e.pn = {12'hFFF, pn}; e.rc = {1'b0, rc};
        e.busy = busy; e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic expect_b(input int at, input logic [23:0] pn, input logic [1:0] rc,
                            input logic busy, input string nm);
        exp_t e;
        e.at = at; e.dut = 1'b1; e.pn = pn; e.rc = rc; e.busy = busy; e.nm = nm;
        sb.push_back(e);
    endtask

    // Monitor: on each falling edge retire every expectation due by now
    exp_t        m_e;
    logic [23:0] m_pn;
    logic [1:0]  m_rc;
    logic        m_busy;
    always @(negedge clk_sys) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            m_e = sb.pop_front();
            if (m_e.dut == 1'b0) begin
                m_pn = {12'hFFF, port_n_a}; m_rc = {1'b0, rot_cur_a}; m_busy = rot_busy_a;
            end else begin
                m_pn = port_n_b; m_rc = rot_cur_b; m_busy = rot_busy_b;
            end
            checks++;
            if (m_e.at != cyc || m_pn !== m_e.pn || m_rc !== m_e.rc || m_busy !== m_e.busy) begin
                failures++;
                $display("FAIL %s cyc=%0d(due %0d): got port_n=%h rot_cur=%0d busy=%b, want port_n=%h rot_cur=%0d busy=%b",
                         m_e.nm, cyc, m_e.at, m_pn, m_rc, m_busy, m_e.pn, m_e.rc, m_e.busy);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    int r0;
    int p;
    int t1;
    int u;

    initial begin
        reset_n = 1'b0;
        joy_a = '0; rot_req_a = 1'b0; af_en_a = '0; af_mask_a = '0; af_rate_a = '0;
        joy_b = '0; rot_req_b = '0;   af_en_b = '0; af_mask_b = '0; af_rate_b = '0;

        // Reset values
        step(2);
        expect_a(cyc, 12'hFFF, 1'b0, 1'b0, "reset_a");
        expect_b(cyc, 24'hFFFFFF, 2'd0, 1'b0, "reset_b");
        step(1);
        reset_n = 1'b1;
        r0 = cyc;

        // Straight routing, one cycle latency, upper bits ignored
        step(1); joy_a[15:0] = 16'h0008;
        expect_a(cyc + 1, 12'hFFE, 1'b0, 1'b0, "src0_up");
        step(1); joy_a[15:0] = 16'hFFC0;
        expect_a(cyc + 1, 12'hFFF, 1'b0, 1'b0, "upper_bits_ignored");
        step(1); joy_a = 32'h0003_0000;
        expect_a(cyc + 1, {6'b110011, 6'b111111}, 1'b0, 1'b0, "src1_right_left");
        step(1); joy_a = '0; af_en_a = 2'b01; af_mask_a = 2'b01; af_rate_a = 2'd0;

        // Autofire on src0 p6, rate 0 -> 8 ticks of 4 clocks per half period
        step(1); p = cyc; joy_a[15:0] = 16'h0010;
        t1 = r0 + 4 * ((p + 1 - r0 + 3) / 4);
        expect_a(p + 1,   12'hFEF, 1'b0, 1'b0, "af_first_press");
        expect_a(t1 + 28, 12'hFEF, 1'b0, 1'b0, "af_first_half_end");
        expect_a(t1 + 29, 12'hFFF, 1'b0, 1'b0, "af_gap_start");
        expect_a(t1 + 60, 12'hFFF, 1'b0, 1'b0, "af_gap_end");
        expect_a(t1 + 61, 12'hFEF, 1'b0, 1'b0, "af_second_press");
        step(t1 + 69 - cyc);
        expect_a(cyc, 12'hFEF, 1'b0, 1'b0, "af_held");
        joy_a = '0; af_en_a = 2'b00;
        expect_a(cyc + 1, 12'hFFF, 1'b0, 1'b0, "af_release");

        // Swap requested while src0 fire is held: blocked until quiet
        step(1); joy_a[15:0] = 16'h0010;
        expect_a(cyc + 1, 12'hFEF, 1'b0, 1'b0, "fire_held_no_af");
        step(1); rot_req_a = 1'b1;
        expect_a(cyc + 1, 12'hFEF, 1'b0, 1'b1, "rot_pending_busy");
        step(50);
        expect_a(cyc, 12'hFEF, 1'b0, 1'b1, "rot_blocked_while_held");
        joy_a = '0; u = cyc;
        expect_a(u + 1,    12'hFFF, 1'b0, 1'b1, "rot_quiet_start");
        expect_a(u + 2048, 12'hFFF, 1'b0, 1'b1, "rot_apply_cycle");
        expect_a(u + 2049, 12'hFFF, 1'b1, 1'b0, "rot_applied");
        step(2049); joy_a[31:16] = 16'h0008;
        expect_a(cyc + 1, 12'hFFE, 1'b1, 1'b0, "swap_src1_to_port0");

        // Request reverted before the quiet time expires: nothing applied
        step(1); joy_a = '0; rot_req_a = 1'b0;
        expect_a(cyc + 1, 12'hFFF, 1'b1, 1'b1, "revert_pending");
        step(100);
        expect_a(cyc, 12'hFFF, 1'b1, 1'b1, "revert_still_pending");
        rot_req_a = 1'b1;
        expect_a(cyc + 1,   12'hFFF, 1'b1, 1'b0, "revert_cancelled");
        expect_a(cyc + 120, 12'hFFF, 1'b1, 1'b0, "revert_no_change");
        step(120);

        // Four ports, rotation 3
        rot_req_b = 2'd3;
        expect_b(cyc + 1,  24'hFFFFFF, 2'd0, 1'b1, "b_pending");
        expect_b(cyc + 17, 24'hFFFFFF, 2'd0, 1'b1, "b_apply_cycle");
        expect_b(cyc + 18, 24'hFFFFFF, 2'd3, 1'b0, "b_applied");
        step(18);
        joy_b = {16'h0008, 16'h0002, 16'h0001, 16'h0004};
        expect_b(cyc + 1, {6'b111011, 6'b110111, 6'b111101, 6'b111110}, 2'd3, 1'b0, "b_rot3_map");
        step(1); joy_b = '0;

        // Asynchronous reset during autofire and during a pending rotation
        af_en_a = 2'b01; joy_a[15:0] = 16'h0010; rot_req_a = 1'b0; rot_req_b = 2'd1;
        expect_a(cyc + 1, 12'hBFF, 1'b1, 1'b1, "a_af_held_rot1");
        step(10);
        expect_a(cyc, 12'hBFF, 1'b1, 1'b1, "a_before_reset");
        expect_b(cyc, 24'hFFFFFF, 2'd3, 1'b1, "b_before_reset");
        step(1); #1;
        reset_n = 1'b0; joy_a = '0; af_en_a = 2'b00;
        expect_a(cyc, 12'hFFF, 1'b0, 1'b0, "a_async_reset");
        expect_b(cyc, 24'hFFFFFF, 2'd0, 1'b0, "b_async_reset");
        step(2); reset_n = 1'b1;
        expect_a(cyc + 1,  12'hFFF, 1'b0, 1'b0, "a_after_reset");
        expect_b(cyc + 1,  24'hFFFFFF, 2'd0, 1'b1, "b_restart_from_req");
        expect_b(cyc + 17, 24'hFFFFFF, 2'd0, 1'b1, "b_apply_after_reset");
        expect_b(cyc + 18, 24'hFFFFFF, 2'd1, 1'b0, "b_applied_after_reset");
        step(20);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 20 && sb.size() > 0; i++) step(1);
        if (sb.size() > 0) begin
            failures += sb.size();
            $display("FAIL scoreboard_drain: pending=%0d want 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
